// File: rtl/score_update_ctrl_pkg.sv
// Shared constants and the controller state type for the score overlay path.
//   SCORE_W   : width of the binary score
//   MAX_SCORE : saturation ceiling (three BCD digits)
//   BCD_W     : width of the packed {hundreds, tens, ones} digits
//   FRAME_PIX : pixels per 640x480 frame; the scan address wraps FRAME_PIX-1 -> 0
package score_pkg;

    localparam int SCORE_W   = 10;
    localparam int MAX_SCORE = 999;
    localparam int BCD_W     = 12;
    localparam int FRAME_PIX = 640 * 480;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONVERT    = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

endpackage

// File: rtl/score_update_ctrl_bin2bcd.sv
// Multi-cycle binary-to-BCD converter (double-dabble, one bit per cycle).
// Ports:
//   clk, resetn : clock and asynchronous active-low reset
//   i_start     : load i_bin and begin a conversion (restarts one in flight)
//   i_bin       : binary value to convert, sampled on i_start
//   o_done      : high in the cycle whose clock edge completes the last shift
//   o_bcd       : packed digits; holds the result from o_done until the next i_start
module score_bin2bcd
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_bin,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic               r_active;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic [SCORE_W-1:0] r_bin;
    logic [BCD_W-1:0]   w_adj;

    // Any digit of 5 or more gets +3 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] res;
        res = d;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (d[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    assign w_adj  = add3(r_bcd);
    assign o_done = r_active && (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;

    // Control: counts the SCORE_W shift cycles of one conversion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= CNT_W'(SCORE_W);
        end else if (r_active) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_active <= 1'b0;
            end
        end
    end

    // Datapath: only meaningful after a start, so it carries no reset.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_bcd <= '0;
            r_bin <= i_bin;
        end else if (r_active) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
            r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/score_update_ctrl.sv
// Score update sequencer for the score overlay.
// Arbitrates score deltas from NUM_REQ sources (round-robin), keeps a saturating
// working score, converts it to BCD, and commits score/digits only when the pixel
// scan wraps so the displayed panel never changes mid-frame.
// Ports:
//   clk, resetn  : clock and asynchronous active-low reset
//   address      : current pixel scan address; a decrease marks a frame start
//   req_valid    : per-requester delta valid
//   req_delta    : per-requester delta, requester i at [i*DELTA_W +: DELTA_W]
//   req_ready    : one-hot grant; valid & ready in a cycle accepts the delta
//   clear_score  : zero the working score (overrides any request that cycle)
//   score_out    : committed score
//   bcd_out      : committed digits {hundreds, tens, ones}
//   commit       : one-cycle pulse when score_out/bcd_out update
//   busy         : high whenever the controller is not idle
module score_update_ctrl
    import score_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DELTA_W = 4,
    parameter int ADDR_W  = 19
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [ADDR_W-1:0]          address,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DELTA_W-1:0] req_delta,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       clear_score,
    output logic [SCORE_W-1:0]         score_out,
    output logic [BCD_W-1:0]           bcd_out,
    output logic                       commit,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SCORE_W:0]   MAX_EXT = (SCORE_W + 1)'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_work, w_work_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0]  r_prev_addr;

    logic               w_frame_start;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_found;
    logic               w_accept;
    logic [DELTA_W-1:0] w_delta;
    logic [SCORE_W:0]   w_sum;
    logic               w_start;
    logic               w_commit;
    logic               w_conv_done;
    logic [BCD_W-1:0]   w_bcd;

    // One extra bit of headroom lets the sum exceed the ceiling before clamping.
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W:0] sum);
        if (sum > MAX_EXT) begin
            return MAX_VAL;
        end
        return sum[SCORE_W-1:0];
    endfunction

    assign w_frame_start = (address < r_prev_addr);

    // Round-robin search starting at the requester after the last grantee.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[PTR_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_found = 1'b1;
                w_gidx  = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
                w_grant[PTR_W'((int'(r_ptr) + k) % NUM_REQ)] = 1'b1;
            end
        end
    end

    always_comb begin
        w_delta = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gidx == PTR_W'(k)) begin
                w_delta = req_delta[k*DELTA_W +: DELTA_W];
            end
        end
    end

    // Grants are masked during reset, while converting, and when a clear is pending.
    assign req_ready = (resetn && !clear_score && (r_state != CONVERT)) ? w_grant : '0;
    assign w_accept  = |req_ready;
    assign w_sum     = {1'b0, r_work} + {{(SCORE_W + 1 - DELTA_W){1'b0}}, w_delta};
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_ptr_nxt   = r_ptr;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        if (clear_score) begin
            w_work_nxt  = '0;
            w_start     = 1'b1;
            w_state_nxt = CONVERT;
        end else begin
            unique case (r_state)
                IDLE, WAIT_FRAME: begin
                    // An accept restarts conversion and defers any commit, even
                    // when it lands on the frame-start cycle.
                    if (w_accept) begin
                        w_work_nxt  = sat_score(w_sum);
                        w_ptr_nxt   = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
                        w_start     = 1'b1;
                        w_state_nxt = CONVERT;
                    end else if (r_state == WAIT_FRAME && w_frame_start) begin
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                CONVERT: begin
                    if (w_conv_done) begin
                        w_state_nxt = WAIT_FRAME;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // The converter samples the post-update score in the same cycle as the accept.
    score_bin2bcd u_bin2bcd (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (w_start),
        .i_bin   (w_work_nxt),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_work      <= '0;
            r_ptr       <= '0;
            r_prev_addr <= '0;
            score_out   <= '0;
            bcd_out     <= '0;
            commit      <= 1'b0;
        end else begin
            r_work      <= w_work_nxt;
            r_ptr       <= w_ptr_nxt;
            r_prev_addr <= address;
            commit      <= w_commit;
            if (w_commit) begin
                score_out <= r_work;
                bcd_out   <= w_bcd;
            end
        end
    end

endmodule

// File: tb/tb_score_update_ctrl.sv
module tb_score_update_ctrl;
    import score_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int DELTA_W = 4;
    localparam int ADDR_W  = 19;

    logic                       clk = 1'b0;
    logic                       resetn = 1'b0;
    logic [ADDR_W-1:0]          address = '0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*DELTA_W-1:0] req_delta = '0;
    logic                       clear_score = 1'b0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [SCORE_W-1:0]         score_out;
    logic [BCD_W-1:0]           bcd_out;
    logic                       commit;
    logic                       busy;

    score_update_ctrl #(.NUM_REQ(NUM_REQ), .DELTA_W(DELTA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .address     (address),
        .req_valid   (req_valid),
        .req_delta   (req_delta),
        .req_ready   (req_ready),
        .clear_score (clear_score),
        .score_out   (score_out),
        .bcd_out     (bcd_out),
        .commit      (commit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int score;
        int bcd;
        int cyc;
    } exp_t;
    exp_t expq[$];

    // Reference model: score value, whether a result is still owed to the
    // display, and when the last (re)start of conversion happened.
    int m_work, m_start, m_ptr, m_prev_addr;
    bit m_pending;
    bit rq_pend[NUM_REQ];
    int rq_d[NUM_REQ];
    int scan = 0;
    int frame_len = 30;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_work = 0; m_pending = 0; m_ptr = 0; m_prev_addr = 0; m_start = 0;
        expq.delete();
        for (int i = 0; i < NUM_REQ; i++) begin rq_pend[i] = 0; rq_d[i] = 0; end
        scan = 0;
    endtask

    // Monitor: every commit pulse must match the oldest owed result, one cycle
    // after the frame-start cycle that produced it.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (commit) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_commit actual=1 required=0 score_out=%0d (cycle %0d)", score_out, cyc);
                end else begin
                    e = expq.pop_front();
                    check("commit_cycle", cyc - 1, e.cyc);
                    check("score_out", int'(score_out), e.score);
                    check("bcd_out", int'(bcd_out), e.bcd);
                end
            end
            if (expq.size() > 0 && expq[0].cyc < cyc - 1) begin
                checks++; errors++;
                $display("FAIL missing_commit actual=0 required=1 score=%0d (cycle %0d)", expq[0].score, cyc);
                void'(expq.pop_front());
            end
        end
    end

    task automatic step(input bit clr, input int a);
        int  g, exp_ready;
        bit  conv, fs;
        @(negedge clk);
        address     = ADDR_W'(a);
        clear_score = clr;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = rq_pend[i];
            req_delta[i*DELTA_W +: DELTA_W] = DELTA_W'(rq_d[i]);
        end
        #1;
        fs   = (a < m_prev_addr);
        conv = m_pending && (cyc - m_start <= SCORE_W);
        g    = -1;
        if (!clr && !conv) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && rq_pend[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        check("req_ready", int'(req_ready), exp_ready);
        check("busy", int'(busy), int'(m_pending));
        if (clr) begin
            m_work = 0; m_pending = 1; m_start = cyc;
        end else if (g >= 0) begin
            m_work = imin(m_work + rq_d[g], MAX_SCORE);
            m_pending = 1; m_start = cyc;
            m_ptr = (g + 1) % NUM_REQ;
            rq_pend[g] = 0;
        end else if (m_pending && !conv && fs) begin
            expq.push_back('{m_work, to_bcd(m_work), cyc});
            m_pending = 0;
        end
        m_prev_addr = a;
    endtask

    task automatic tick(input bit clr);
        int a;
        if (scan >= frame_len) scan = 0; else scan++;
        a = (scan == frame_len) ? FRAME_PIX - 1 : scan;
        step(clr, a);
    endtask

    task automatic wait_grant(input int i);
        int n = 0;
        while (rq_pend[i] && n < 200) begin tick(0); n++; end
        check("grant_timeout", int'(rq_pend[i]), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; clear_score = 1'b0; req_valid = '0; address = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_score", int'(score_out), 0);
        check("rst_bcd", int'(bcd_out), 0);
        check("rst_commit", int'(commit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(req_ready), 0);
        resetn = 1'b1;

        // Single delta, one wrap
        rq_pend[0] = 1; rq_d[0] = 5;
        repeat (80) tick(0);
        check("t1_score", int'(score_out), 5);
        check("t1_bcd", int'(bcd_out), 'h005);

        // Two simultaneous requesters from a fresh pointer
        do_reset();
        rq_pend[0] = 1; rq_d[0] = 3; rq_pend[1] = 1; rq_d[1] = 4;
        repeat (100) tick(0);
        check("t2_score", int'(score_out), 7);

        // Climb to 997 then overflow to the ceiling
        tick(1);
        for (int j = 0; j < 67; j++) begin
            rq_pend[0] = 1; rq_d[0] = (j < 66) ? 15 : 7;
            wait_grant(0);
        end
        rq_pend[0] = 1; rq_d[0] = 9;
        wait_grant(0);
        repeat (100) tick(0);
        check("t3_score", int'(score_out), 999);
        check("t3_bcd", int'(bcd_out), 'h999);

        // Accept coinciding with frame start defers the commit
        tick(1);
        repeat (60) tick(0);
        rq_pend[1] = 1; rq_d[1] = 2;
        repeat (13) step(0, 5);
        rq_pend[0] = 1; rq_d[0] = 6;
        step(0, 0);
        step(0, 0);
        check("t4_no_commit", int'(commit), 0);
        repeat (12) step(0, 0);
        step(0, 100);
        step(0, 0);
        step(0, 0);
        check("t4_score", int'(score_out), 8);
        scan = 0;

        // Clear beats a valid request
        rq_pend[0] = 1; rq_d[0] = 4;
        tick(1);
        rq_pend[0] = 0;
        repeat (60) tick(0);
        check("t5_score", int'(score_out), 0);
        check("t5_bcd", int'(bcd_out), 0);

        // Reset in the middle of a conversion
        rq_pend[0] = 1; rq_d[0] = 3;
        wait_grant(0);
        repeat (60) tick(0);
        check("t6_pre_score", int'(score_out), 3);
        rq_pend[0] = 1; rq_d[0] = 2;
        wait_grant(0);
        repeat (3) tick(0);
        #2;
        resetn = 1'b0; address = '0; req_valid = '0; clear_score = 1'b0;
        #1;
        check("t6_score", int'(score_out), 0);
        check("t6_bcd", int'(bcd_out), 0);
        check("t6_commit", int'(commit), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_ready", int'(req_ready), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (40) tick(0);
        check("t6_post_score", int'(score_out), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rq_pend[i] && $urandom_range(0, 15) == 0) begin
                    rq_pend[i] = 1;
                    rq_d[i] = int'($urandom_range(0, 15));
                end
            end
            if (scan == 0) frame_len = int'($urandom_range(12, 40));
            tick($urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < NUM_REQ; i++) rq_pend[i] = 0;
        repeat (120) tick(0);
        check("queue_empty", expq.size(), 0);
        check("final_score", int'(score_out), m_work);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
